// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_cond_negate.sv
// Conditional two's-complement negation; combinational helper for sign fix-up.
module mdu_cond_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             negate,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit owning the architectural HI/LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               busy_d, done_d;

  logic               signed_op;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift, div_diff;
  logic               div_ok;
  logic [DW-1:0]      prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign signed_op = ~op[0];
  assign neg_a     = signed_op & rs_data[WIDTH-1];
  assign neg_b     = signed_op & rt_data[WIDTH-1];

  // Operand magnitudes; signed ops run unsigned and are fixed up afterwards.
  mdu_cond_negate #(.WIDTH(WIDTH)) u_abs_a (.negate(neg_a), .value(rs_data), .result_c(abs_a));
  mdu_cond_negate #(.WIDTH(WIDTH)) u_abs_b (.negate(neg_b), .value(rt_data), .result_c(abs_b));

  mdu_cond_negate #(.WIDTH(DW)) u_fix_prod (
    .negate(sign_a_q ^ sign_b_q), .value(acc_q), .result_c(prod_res)
  );
  mdu_cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .negate(sign_a_q ^ sign_b_q), .value(acc_q[WIDTH-1:0]), .result_c(quo_res)
  );
  mdu_cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .negate(sign_a_q), .value(rem_q[WIDTH-1:0]), .result_c(rem_res)
  );

  // One shift-add step (multiplier in acc low half) and one restoring step (quotient in acc low half).
  assign mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    hi_d       = hi;
    lo_d       = lo;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = CNT_W'(ITER_COUNT - 1);
          is_div_d   = op[1];
          sign_a_d   = neg_a;
          sign_b_d   = neg_b;
          div_zero_d = (rt_data == '0);
          opnd_d     = op[1] ? abs_b : abs_a;
          acc_d      = {WIDTH'(0), (op[1] ? abs_a : abs_b)};
          rem_d      = '0;
        end else begin
          if (hi_we) hi_d = rs_data;
          if (lo_we) lo_d = rs_data;
        end
      end
      RUN: begin
        if (is_div_q) begin
          rem_d = div_ok ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
          acc_d = {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[DW-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          hi_d = rem_res;
          lo_d = div_zero_q ? '1 : quo_res;
        end else begin
          hi_d = prod_res[DW-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      hi         <= hi_d;
      lo         <= lo_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: results, latency, busy/done and HI/LO writes.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle and returns in the done cycle (or after a bounded wait).
  // inj > 0 pulses start/hi_we/lo_we with junk operands in that busy cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output int busy_cyc,
                        output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    int k;
    busy_cyc = 0;
    mid_hi = 'x;
    mid_lo = 'x;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k <= 40) begin
      if (busy === 1'b1) busy_cyc++;
      if (k == 20) begin mid_hi = hi; mid_lo = lo; end
      if (inj != 0 && k == inj) begin
        start = 1'b1; op = OP_MULTU; rs_data = 32'h0000DEAD; rt_data = 32'd2;
        hi_we = 1'b1; lo_we = 1'b1;
      end else if (inj != 0 && k == inj + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      tick();
      k++;
    end
    lat = (done === 1'b1) ? k : -1;
    rh = hi;
    rl = lo;
  endtask

  task automatic test_reset();
    int k;
    bit seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end

    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'hA5A5A5A5;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    op = OP_DIV; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (k < 10) begin tick(); k++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL midreset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL midreset_lo got=%h exp=%h", lo, 32'h0); end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_multu_timing();
    logic [31:0] rh, rl, mh, ml;
    int lat, bc;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, rh, rl, lat, bc, mh, ml);
    checks++; if (rh !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=%h", rh, 32'hFFFFFFFE); end
    checks++; if (rl !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=%h", rl, 32'h1); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", lat); end
    checks++; if (bc !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_width got=%b exp=0", done); end
  endtask

  task automatic test_mult_div();
    logic [1:0]  vo [9];
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] eh [9];
    logic [31:0] el [9];
    logic [31:0] rh, rl, mh, ml;
    int lat, bc;
    vo = '{OP_MULT, OP_MULT, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    va = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7,
           32'h80000000, 32'd100, 32'd7, 32'hFFFFFFFB};
    vb = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd0,
           32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd0};
    eh = '{32'hFFFFFFFF, 32'h40000000, 32'h0, 32'hFFFFFFFF, 32'd7,
           32'h0, 32'd2, 32'd1, 32'hFFFFFFFB};
    el = '{32'hFFFFFFEB, 32'h0, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF,
           32'h80000000, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF};
    for (int i = 0; i < 9; i++) begin
      run_op(vo[i], va[i], vb[i], 0, rh, rl, lat, bc, mh, ml);
      checks++;
      if (rh !== eh[i] || rl !== el[i] || lat !== 34) begin
        failures++;
        $display("FAIL vec%0d op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d exp hi=%h lo=%h lat=34",
                 i, vo[i], va[i], vb[i], rh, rl, lat, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl, mh, ml;
    int lat, bc;
    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h00001111;
    tick();
    lo_we = 1'b0; rs_data = 32'h00002222;
    hi_we = 1'b0; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    run_op(OP_MULTU, 32'd3, 32'd5, 5, rh, rl, lat, bc, mh, ml);
    checks++; if (mh !== 32'h00001111) begin failures++; $display("FAIL busy_hi_held got=%h exp=%h", mh, 32'h1111); end
    checks++; if (ml !== 32'h00002222) begin failures++; $display("FAIL busy_lo_held got=%h exp=%h", ml, 32'h2222); end
    checks++; if (rh !== 32'h0 || rl !== 32'd15) begin failures++; $display("FAIL busy_ignore_result got=%h_%h exp=%h_%h", rh, rl, 32'h0, 32'd15); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=34", lat); end
    run_op(OP_MULTU, 32'd6, 32'd7, 0, rh, rl, lat, bc, mh, ml);
    checks++; if (rh !== 32'h0 || rl !== 32'd42) begin failures++; $display("FAIL b2b_result got=%h_%h exp=%h_%h", rh, rl, 32'h0, 32'd42); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] rh, rl, mh, ml;
    int lat, bc;
    lo_we = 1'b1; rs_data = 32'h0BADF00D;
    tick();
    lo_we = 1'b0; hi_we = 1'b1; rs_data = 32'h12345678;
    tick();
    hi_we = 1'b0;
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=%h", hi, 32'h12345678); end
    checks++; if (lo !== 32'h0BADF00D) begin failures++; $display("FAIL mthi_lo_kept got=%h exp=%h", lo, 32'h0BADF00D); end
    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h000055AA;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (hi !== 32'h55AA || lo !== 32'h55AA) begin failures++; $display("FAIL mthi_mtlo_both got=%h_%h exp=%h_%h", hi, lo, 32'h55AA, 32'h55AA); end
    // Start with lo_we: the cycle's MTLO must be dropped, so LO holds until the product lands.
    lo_we = 1'b1;
    run_op(OP_MULTU, 32'd2, 32'd3, 0, rh, rl, lat, bc, mh, ml);
    lo_we = 1'b0;
    checks++; if (ml !== 32'h55AA) begin failures++; $display("FAIL start_lo_we_ignored got=%h exp=%h", ml, 32'h55AA); end
    checks++; if (rl !== 32'd6 || lat !== 34) begin failures++; $display("FAIL start_lo_we_op got lo=%h lat=%0d exp lo=%h lat=34", rl, lat, 32'd6); end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_mult_div();
    test_back_to_back();
    test_mthi_mtlo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
